demultiplexor_1a4: RTL and testbench

Registered 1-to-4 demultiplexor. Routes a WIDTH-bit data word X to one of four outputs A/B/C/D according to Selector. Non-selected outputs are driven to zero. Used as a generic fan-out stage feeding four downstream consumers; flags out-of-range selector codes.

---
 rtl/demultiplexor_1a4.sv | 79 +++++++
 tb/tb_demultiplexor_1a4.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/demultiplexor_1a4.sv
// Registered 1-to-4 demultiplexor: routes X to one of A..D, zeroes the rest, and flags out-of-range selectors.
// Optional build macro DEMUX_OOR_STICKY_EN adds clr_err input and oor_sticky output (latched out-of-range flag).
module demultiplexor_1a4 #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     X,
    input  logic [SEL_WIDTH-1:0] Selector,
    input  logic                 en,
`ifdef DEMUX_OOR_STICKY_EN
    input  logic                 clr_err,
    output logic                 oor_sticky,
`endif
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     D,
    output logic                 sel_oor
);

    localparam logic [SEL_WIDTH-1:0] LAST_CODE = SEL_WIDTH'(3);

    logic             oor_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] c_p0;
    logic [WIDTH-1:0] d_p0;

    assign oor_p0 = (Selector > LAST_CODE);

    // Stage p0: decode the selector into next-state values for each channel
    always_comb begin
        a_p0 = '0;
        b_p0 = '0;
        c_p0 = '0;
        d_p0 = '0;
        if (!oor_p0) begin
            case (Selector[1:0])
                2'd0:    a_p0 = X;
                2'd1:    b_p0 = X;
                2'd2:    c_p0 = X;
                default: d_p0 = X;
            endcase
        end
    end

    // Stage p1: output registers, updated only on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A       <= '0;
            B       <= '0;
            C       <= '0;
            D       <= '0;
            sel_oor <= 1'b0;
        end else if (en) begin
            A       <= a_p0;
            B       <= b_p0;
            C       <= c_p0;
            D       <= d_p0;
            sel_oor <= oor_p0;
        end
    end

`ifdef DEMUX_OOR_STICKY_EN
    // Set wins over clear so an error captured on the clearing edge is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oor_sticky <= 1'b0;
        end else if (en && oor_p0) begin
            oor_sticky <= 1'b1;
        end else if (clr_err) begin
            oor_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_demultiplexor_1a4.sv
// Directed self-checking bench for demultiplexor_1a4; sticky-flag scenario runs when DEMUX_OOR_STICKY_EN is defined.
module tb_demultiplexor_1a4;

    logic       clk;
    logic       rst_n;
    logic [3:0] X;
    logic [2:0] Selector;
    logic       en;
    logic [3:0] A, B, C, D;
    logic       sel_oor;
`ifdef DEMUX_OOR_STICKY_EN
    logic       clr_err;
    logic       oor_sticky;
`endif

    int errors = 0;
    int checks = 0;

    demultiplexor_1a4 #(.WIDTH(4), .SEL_WIDTH(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .X(X),
        .Selector(Selector),
        .en(en),
`ifdef DEMUX_OOR_STICKY_EN
        .clr_err(clr_err),
        .oor_sticky(oor_sticky),
`endif
        .A(A),
        .B(B),
        .C(C),
        .D(D),
        .sel_oor(sel_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    // Expected outputs are packed {A,B,C,D,sel_oor}
    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; X = 4'b1011; Selector = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== 17'h0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", {A, B, C, D, sel_oor}, 17'h0);
        end
`ifdef DEMUX_OOR_STICKY_EN
        checks++;
        if (oor_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got %b expected 0", oor_sticky);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== 17'h0) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", {A, B, C, D, sel_oor}, 17'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== 17'h0) begin
            errors++;
            $display("FAIL reset_release_no_en: got %h expected %h", {A, B, C, D, sel_oor}, 17'h0);
        end
    endtask

    task automatic test_routing();
        logic [15:0] exp_tab [4] = '{16'hB000, 16'h0B00, 16'h00B0, 16'h000B};
        en = 1'b1; X = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            Selector = 3'(i);
            @(posedge clk); #1;
            checks++;
            if ({A, B, C, D, sel_oor} !== {exp_tab[i], 1'b0}) begin
                errors++;
                $display("FAIL route_sel%0d: got %h expected %h", i, {A, B, C, D, sel_oor}, {exp_tab[i], 1'b0});
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0]  sel_tab [3] = '{3'b100, 3'b101, 3'b000};
        logic [16:0] exp_tab [3] = '{{16'h0000, 1'b1}, {16'h0000, 1'b1}, {16'hB000, 1'b0}};
        en = 1'b1; X = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            Selector = sel_tab[i];
            @(posedge clk); #1;
            checks++;
            if ({A, B, C, D, sel_oor} !== exp_tab[i]) begin
                errors++;
                $display("FAIL oor_step%0d: got %h expected %h", i, {A, B, C, D, sel_oor}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        en = 1'b1; X = 4'b1011; Selector = 3'b010;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== {16'h00B0, 1'b0}) begin
            errors++;
            $display("FAIL hold_capture: got %h expected %h", {A, B, C, D, sel_oor}, {16'h00B0, 1'b0});
        end
        en = 1'b0; X = 4'b0110; Selector = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({A, B, C, D, sel_oor} !== {16'h00B0, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h expected %h", i, {A, B, C, D, sel_oor}, {16'h00B0, 1'b0});
            end
        end
        en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== {16'h6000, 1'b0}) begin
            errors++;
            $display("FAIL hold_resume: got %h expected %h", {A, B, C, D, sel_oor}, {16'h6000, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; X = 4'b1011; Selector = 3'b011;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== {16'h000B, 1'b0}) begin
            errors++;
            $display("FAIL mid_held: got %h expected %h", {A, B, C, D, sel_oor}, {16'h000B, 1'b0});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== 17'h0) begin
            errors++;
            $display("FAIL mid_async_clear: got %h expected %h", {A, B, C, D, sel_oor}, 17'h0);
        end
        #1 rst_n = 1'b1;
        en = 1'b1; X = 4'b1011; Selector = 3'b001;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, sel_oor} !== {16'h0B00, 1'b0}) begin
            errors++;
            $display("FAIL mid_first_capture: got %h expected %h", {A, B, C, D, sel_oor}, {16'h0B00, 1'b0});
        end
    endtask

`ifdef DEMUX_OOR_STICKY_EN
    // Expected values are packed {sel_oor, oor_sticky}
    task automatic test_sticky();
        logic [2:0] sel_tab [4] = '{3'b110, 3'b001, 3'b010, 3'b111};
        logic       clr_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] exp_tab [4] = '{2'b11, 2'b01, 2'b00, 2'b11};
        en = 1'b1; X = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            Selector = sel_tab[i];
            clr_err  = clr_tab[i];
            @(posedge clk); #1;
            checks++;
            if ({sel_oor, oor_sticky} !== exp_tab[i]) begin
                errors++;
                $display("FAIL sticky_step%0d: got %b expected %b", i, {sel_oor, oor_sticky}, exp_tab[i]);
            end
        end
        clr_err = 1'b0;
    endtask
`endif

    initial begin
`ifdef DEMUX_OOR_STICKY_EN
        clr_err = 1'b0;
`endif
        test_reset();
        test_routing();
        test_out_of_range();
        test_enable_hold();
        test_reset_mid();
`ifdef DEMUX_OOR_STICKY_EN
        test_sticky();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
